// File: rtl/dla_platform_csr_pkg.sv
`default_nettype none
// ============================================================================
// Package : dla_platform_csr_pkg
// Shared port count and FSM state encodings for the platform CSR AXI demux.
// Rev     : 1.0
// ============================================================================
package dla_platform_csr_pkg;

    localparam int NUM_CSR_PORTS = 2;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2,
        R_RESP = 2'd3
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE  = 2'd0,
        W_REQ   = 2'd1,
        W_RESP  = 2'd2,
        W_BRESP = 2'd3
    } wr_state_e;

endpackage
`default_nettype wire

// File: rtl/dla_platform_csr_axi_demux.sv
`default_nettype none
// ============================================================================
// Module : dla_platform_csr_axi_demux
// Steers the host CSR AXI4-Lite port to one of two CoreDLA CSR ports by one
// address bit; one outstanding read and one outstanding write.
// Rev    : 1.0
// ============================================================================
module dla_platform_csr_axi_demux
    import dla_platform_csr_pkg::*;
#(
    parameter int CSR_ADDR_WIDTH = 11,
    parameter int CSR_DATA_WIDTH = 32,
    parameter int SEL_BIT        = 10
) (
    input  logic                                      clk,
    input  logic                                      i_sclrn,

    input  logic                                      i_arvalid,
    input  logic [CSR_ADDR_WIDTH-1:0]                 i_araddr,
    output logic                                      o_arready,
    output logic                                      o_rvalid,
    output logic [CSR_DATA_WIDTH-1:0]                 o_rdata,
    input  logic                                      i_rready,

    input  logic                                      i_awvalid,
    input  logic [CSR_ADDR_WIDTH-1:0]                 i_awaddr,
    input  logic                                      i_wvalid,
    input  logic [CSR_DATA_WIDTH-1:0]                 i_wdata,
    output logic                                      o_awready,
    output logic                                      o_wready,
    output logic                                      o_bvalid,
    input  logic                                      i_bready,

    output logic [NUM_CSR_PORTS-1:0]                  o_m_arvalid,
    output logic [NUM_CSR_PORTS*CSR_ADDR_WIDTH-1:0]   o_m_araddr,
    input  logic [NUM_CSR_PORTS-1:0]                  i_m_arready,
    input  logic [NUM_CSR_PORTS-1:0]                  i_m_rvalid,
    input  logic [NUM_CSR_PORTS*CSR_DATA_WIDTH-1:0]   i_m_rdata,
    output logic [NUM_CSR_PORTS-1:0]                  o_m_rready,

    output logic [NUM_CSR_PORTS-1:0]                  o_m_awvalid,
    output logic [NUM_CSR_PORTS*CSR_ADDR_WIDTH-1:0]   o_m_awaddr,
    output logic [NUM_CSR_PORTS-1:0]                  o_m_wvalid,
    output logic [NUM_CSR_PORTS*CSR_DATA_WIDTH-1:0]   o_m_wdata,
    input  logic [NUM_CSR_PORTS-1:0]                  i_m_awready,
    input  logic [NUM_CSR_PORTS-1:0]                  i_m_wready,
    input  logic [NUM_CSR_PORTS-1:0]                  i_m_bvalid,
    output logic [NUM_CSR_PORTS-1:0]                  o_m_bready
);

    localparam int NP = NUM_CSR_PORTS;
    localparam int AW = CSR_ADDR_WIDTH;
    localparam int DW = CSR_DATA_WIDTH;

    logic [NP-1:0][DW-1:0] m_rdata_w;
    assign m_rdata_w = i_m_rdata;

    // ------------------------------------------------------------------ read
    rd_state_e             rd_state_q, rd_state_d;
    logic                  rd_sel_q, rd_sel_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q, rvalid_d;
    logic [DW-1:0]         rdata_q, rdata_d;
    logic [NP-1:0]         m_arvalid_q, m_arvalid_d;
    logic [NP-1:0]         m_rready_q, m_rready_d;
    logic [NP-1:0][AW-1:0] m_araddr_q, m_araddr_d;

    always_comb begin
        rd_state_d  = rd_state_q;
        rd_sel_d    = rd_sel_q;
        arready_d   = 1'b0;
        rvalid_d    = rvalid_q;
        rdata_d     = rdata_q;
        m_arvalid_d = m_arvalid_q;
        m_rready_d  = m_rready_q;
        m_araddr_d  = m_araddr_q;
        unique case (rd_state_q)
            R_IDLE: begin
                // arready is a one-cycle registered pulse answering a seen arvalid
                arready_d = i_arvalid && !arready_q;
                if (arready_q && i_arvalid) begin
                    rd_sel_d                       = i_araddr[SEL_BIT];
                    m_araddr_d[i_araddr[SEL_BIT]]  = i_araddr;
                    m_arvalid_d[i_araddr[SEL_BIT]] = 1'b1;
                    rd_state_d                     = R_ADDR;
                end
            end
            R_ADDR: begin
                if (i_m_arready[rd_sel_q]) begin
                    m_arvalid_d[rd_sel_q] = 1'b0;
                    m_rready_d[rd_sel_q]  = 1'b1;
                    rd_state_d            = R_DATA;
                end
            end
            R_DATA: begin
                if (i_m_rvalid[rd_sel_q]) begin
                    rdata_d              = m_rdata_w[rd_sel_q];
                    m_rready_d[rd_sel_q] = 1'b0;
                    rvalid_d             = 1'b1;
                    rd_state_d           = R_RESP;
                end
            end
            R_RESP: begin
                if (i_rready) begin
                    rvalid_d   = 1'b0;
                    rd_state_d = R_IDLE;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!i_sclrn) begin
            rd_state_q  <= R_IDLE;
            rd_sel_q    <= 1'b0;
            arready_q   <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            m_arvalid_q <= '0;
            m_rready_q  <= '0;
            m_araddr_q  <= '0;
        end else begin
            rd_state_q  <= rd_state_d;
            rd_sel_q    <= rd_sel_d;
            arready_q   <= arready_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            m_arvalid_q <= m_arvalid_d;
            m_rready_q  <= m_rready_d;
            m_araddr_q  <= m_araddr_d;
        end
    end

    // ----------------------------------------------------------------- write
    wr_state_e             wr_state_q, wr_state_d;
    logic                  wr_sel_q, wr_sel_d;
    logic                  awready_q, awready_d;
    logic                  bvalid_q, bvalid_d;
    logic [NP-1:0]         m_awvalid_q, m_awvalid_d;
    logic [NP-1:0]         m_wvalid_q, m_wvalid_d;
    logic [NP-1:0]         m_bready_q, m_bready_d;
    logic [NP-1:0][AW-1:0] m_awaddr_q, m_awaddr_d;
    logic [NP-1:0][DW-1:0] m_wdata_q, m_wdata_d;

    always_comb begin
        wr_state_d  = wr_state_q;
        wr_sel_d    = wr_sel_q;
        awready_d   = 1'b0;
        bvalid_d    = bvalid_q;
        m_awvalid_d = m_awvalid_q;
        m_wvalid_d  = m_wvalid_q;
        m_bready_d  = m_bready_q;
        m_awaddr_d  = m_awaddr_q;
        m_wdata_d   = m_wdata_q;
        unique case (wr_state_q)
            W_IDLE: begin
                awready_d = i_awvalid && i_wvalid && !awready_q;
                if (awready_q && i_awvalid && i_wvalid) begin
                    wr_sel_d                       = i_awaddr[SEL_BIT];
                    m_awaddr_d[i_awaddr[SEL_BIT]]  = i_awaddr;
                    m_wdata_d[i_awaddr[SEL_BIT]]   = i_wdata;
                    m_awvalid_d[i_awaddr[SEL_BIT]] = 1'b1;
                    m_wvalid_d[i_awaddr[SEL_BIT]]  = 1'b1;
                    wr_state_d                     = W_REQ;
                end
            end
            W_REQ: begin
                // address and data channels retire independently
                m_awvalid_d[wr_sel_q] = m_awvalid_q[wr_sel_q] && !i_m_awready[wr_sel_q];
                m_wvalid_d[wr_sel_q]  = m_wvalid_q[wr_sel_q] && !i_m_wready[wr_sel_q];
                if (!m_awvalid_d[wr_sel_q] && !m_wvalid_d[wr_sel_q]) begin
                    m_bready_d[wr_sel_q] = 1'b1;
                    wr_state_d           = W_RESP;
                end
            end
            W_RESP: begin
                if (i_m_bvalid[wr_sel_q]) begin
                    m_bready_d[wr_sel_q] = 1'b0;
                    bvalid_d             = 1'b1;
                    wr_state_d           = W_BRESP;
                end
            end
            W_BRESP: begin
                if (i_bready) begin
                    bvalid_d   = 1'b0;
                    wr_state_d = W_IDLE;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!i_sclrn) begin
            wr_state_q  <= W_IDLE;
            wr_sel_q    <= 1'b0;
            awready_q   <= 1'b0;
            bvalid_q    <= 1'b0;
            m_awvalid_q <= '0;
            m_wvalid_q  <= '0;
            m_bready_q  <= '0;
            m_awaddr_q  <= '0;
            m_wdata_q   <= '0;
        end else begin
            wr_state_q  <= wr_state_d;
            wr_sel_q    <= wr_sel_d;
            awready_q   <= awready_d;
            bvalid_q    <= bvalid_d;
            m_awvalid_q <= m_awvalid_d;
            m_wvalid_q  <= m_wvalid_d;
            m_bready_q  <= m_bready_d;
            m_awaddr_q  <= m_awaddr_d;
            m_wdata_q   <= m_wdata_d;
        end
    end

    assign o_arready   = arready_q;
    assign o_rvalid    = rvalid_q;
    assign o_rdata     = rdata_q;
    assign o_m_arvalid = m_arvalid_q;
    assign o_m_araddr  = m_araddr_q;
    assign o_m_rready  = m_rready_q;

    assign o_awready   = awready_q;
    assign o_wready    = awready_q;
    assign o_bvalid    = bvalid_q;
    assign o_m_awvalid = m_awvalid_q;
    assign o_m_awaddr  = m_awaddr_q;
    assign o_m_wvalid  = m_wvalid_q;
    assign o_m_wdata   = m_wdata_q;
    assign o_m_bready  = m_bready_q;

endmodule
`default_nettype wire

// File: tb/tb_dla_platform_csr_axi_demux.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tb_dla_platform_csr_axi_demux
// Directed scoreboard bench with behavioural CSR slaves on both ports.
// Rev    : 1.0
// ============================================================================
module tb_dla_platform_csr_axi_demux;

    localparam int AW = 11;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            i_sclrn;
    logic            i_arvalid, o_arready, o_rvalid, i_rready;
    logic [AW-1:0]   i_araddr;
    logic [DW-1:0]   o_rdata;
    logic            i_awvalid, i_wvalid, o_awready, o_wready, o_bvalid, i_bready;
    logic [AW-1:0]   i_awaddr;
    logic [DW-1:0]   i_wdata;
    logic [1:0]      o_m_arvalid, i_m_arready, i_m_rvalid, o_m_rready;
    logic [2*AW-1:0] o_m_araddr, o_m_awaddr;
    logic [2*DW-1:0] i_m_rdata, o_m_wdata;
    logic [1:0]      o_m_awvalid, o_m_wvalid, i_m_awready, i_m_wready, i_m_bvalid, o_m_bready;

    dla_platform_csr_axi_demux #(
        .CSR_ADDR_WIDTH(AW),
        .CSR_DATA_WIDTH(DW),
        .SEL_BIT       (10)
    ) u_dut (
        .clk(clk), .i_sclrn(i_sclrn),
        .i_arvalid(i_arvalid), .i_araddr(i_araddr), .o_arready(o_arready),
        .o_rvalid(o_rvalid), .o_rdata(o_rdata), .i_rready(i_rready),
        .i_awvalid(i_awvalid), .i_awaddr(i_awaddr), .i_wvalid(i_wvalid), .i_wdata(i_wdata),
        .o_awready(o_awready), .o_wready(o_wready), .o_bvalid(o_bvalid), .i_bready(i_bready),
        .o_m_arvalid(o_m_arvalid), .o_m_araddr(o_m_araddr), .i_m_arready(i_m_arready),
        .i_m_rvalid(i_m_rvalid), .i_m_rdata(i_m_rdata), .o_m_rready(o_m_rready),
        .o_m_awvalid(o_m_awvalid), .o_m_awaddr(o_m_awaddr), .o_m_wvalid(o_m_wvalid),
        .o_m_wdata(o_m_wdata), .i_m_awready(i_m_awready), .i_m_wready(i_m_wready),
        .i_m_bvalid(i_m_bvalid), .o_m_bready(o_m_bready)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // ---------------------------------------------------- slave models
    int          ar_stall[2], r_stall[2], aw_stall[2], w_stall[2], b_stall[2];
    logic [DW-1:0] rd_val[2];
    bit          extra_rvalid[2];
    int          ar_cnt[2], r_cnt[2], aw_cnt[2], w_cnt[2], b_cnt[2];
    bit          pend_r[2], pend_aw[2], pend_w[2];
    bit          ar_hs[2], r_hs[2], aw_hs[2], w_hs[2], b_hs[2];

    always @(negedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (ar_hs[p]) pend_r[p] = 1'b1;
            if (r_hs[p])  pend_r[p] = 1'b0;
            if (aw_hs[p]) pend_aw[p] = 1'b1;
            if (w_hs[p])  pend_w[p] = 1'b1;
            if (b_hs[p]) begin pend_aw[p] = 1'b0; pend_w[p] = 1'b0; end
            if (!i_sclrn) begin pend_r[p] = 1'b0; pend_aw[p] = 1'b0; pend_w[p] = 1'b0; end

            if (o_m_arvalid[p] && i_sclrn) begin i_m_arready[p] = (ar_cnt[p] >= ar_stall[p]); ar_cnt[p]++; end
            else begin ar_cnt[p] = 0; i_m_arready[p] = (ar_stall[p] == 0); end
            if (o_m_awvalid[p] && i_sclrn) begin i_m_awready[p] = (aw_cnt[p] >= aw_stall[p]); aw_cnt[p]++; end
            else begin aw_cnt[p] = 0; i_m_awready[p] = (aw_stall[p] == 0); end
            if (o_m_wvalid[p] && i_sclrn) begin i_m_wready[p] = (w_cnt[p] >= w_stall[p]); w_cnt[p]++; end
            else begin w_cnt[p] = 0; i_m_wready[p] = (w_stall[p] == 0); end

            if (pend_r[p]) begin i_m_rvalid[p] = (r_cnt[p] >= r_stall[p]); r_cnt[p]++; end
            else begin i_m_rvalid[p] = 1'b0; r_cnt[p] = 0; end
            i_m_rvalid[p] = i_m_rvalid[p] | extra_rvalid[p];
            i_m_rdata[p*DW +: DW] = rd_val[p];
            if (pend_aw[p] && pend_w[p]) begin i_m_bvalid[p] = (b_cnt[p] >= b_stall[p]); b_cnt[p]++; end
            else begin i_m_bvalid[p] = 1'b0; b_cnt[p] = 0; end

            ar_hs[p] = i_sclrn && o_m_arvalid[p] && i_m_arready[p];
            r_hs[p]  = i_sclrn && o_m_rready[p]  && i_m_rvalid[p];
            aw_hs[p] = i_sclrn && o_m_awvalid[p] && i_m_awready[p];
            w_hs[p]  = i_sclrn && o_m_wvalid[p]  && i_m_wready[p];
            b_hs[p]  = i_sclrn && o_m_bready[p]  && i_m_bvalid[p];
        end
    end

    // ---------------------------------------------------- scoreboard
    typedef struct { bit port; logic [AW-1:0] addr; } exp_a_t;
    typedef struct { bit port; logic [DW-1:0] data; } exp_d_t;
    typedef struct { logic [DW-1:0] data; int lat; } exp_r_t;
    typedef struct { bit port; int lat; } exp_b_t;

    exp_a_t q_ar[$], q_aw[$];
    exp_d_t q_w[$];
    exp_r_t q_r[$];
    exp_b_t q_b[$];

    int r_hs_cyc, r_rise, w_hs_cyc, b_rise, last_b_port;
    bit prev_rvalid, prev_bvalid;

    always @(negedge clk) begin
        exp_a_t ea;
        exp_d_t ed;
        exp_r_t er;
        exp_b_t eb;
        #1;
        if (i_sclrn) begin
            if (o_arready && i_arvalid) r_hs_cyc = cyc;
            if (o_awready && i_awvalid && i_wvalid) w_hs_cyc = cyc;
            if (o_rvalid && !prev_rvalid) r_rise = cyc;
            if (o_bvalid && !prev_bvalid) b_rise = cyc;
            for (int p = 0; p < 2; p++) begin
                if (o_m_arvalid[p] && i_m_arready[p]) begin
                    if (q_ar.size() == 0) flag("ar_unexpected");
                    else begin
                        ea = q_ar.pop_front();
                        check("ar_port", p, ea.port);
                        check("ar_addr", o_m_araddr[p*AW +: AW], ea.addr);
                    end
                end
                if (o_m_awvalid[p] && i_m_awready[p]) begin
                    if (q_aw.size() == 0) flag("aw_unexpected");
                    else begin
                        ea = q_aw.pop_front();
                        check("aw_port", p, ea.port);
                        check("aw_addr", o_m_awaddr[p*AW +: AW], ea.addr);
                    end
                end
                if (o_m_wvalid[p] && i_m_wready[p]) begin
                    if (q_w.size() == 0) flag("w_unexpected");
                    else begin
                        ed = q_w.pop_front();
                        check("w_port", p, ed.port);
                        check("w_data", o_m_wdata[p*DW +: DW], ed.data);
                    end
                end
                if (o_m_bready[p] && i_m_bvalid[p]) last_b_port = p;
            end
            if (o_rvalid) begin
                if (q_r.size() == 0) flag("rvalid_unexpected");
                else if (i_rready) begin
                    er = q_r.pop_front();
                    check("rdata", o_rdata, er.data);
                    check("r_latency", r_rise - r_hs_cyc, er.lat);
                end else begin
                    check("rdata_hold", o_rdata, q_r[0].data);
                end
            end
            if (o_bvalid && i_bready) begin
                if (q_b.size() == 0) flag("bvalid_unexpected");
                else begin
                    eb = q_b.pop_front();
                    check("b_port", last_b_port, eb.port);
                    check("b_latency", b_rise - w_hs_cyc, eb.lat);
                end
            end
        end
        prev_rvalid = o_rvalid;
        prev_bvalid = o_bvalid;
    end

    // ---------------------------------------------------- host driver
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_read(input logic [AW-1:0] a);
        int n = 0;
        i_arvalid = 1'b1;
        i_araddr  = a;
        while (!o_arready) begin
            tick();
            n++;
            if (n > 50) begin flag("arready_timeout"); break; end
        end
        tick();
        i_arvalid = 1'b0;
    endtask

    task automatic host_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n = 0;
        i_awvalid = 1'b1;
        i_wvalid  = 1'b1;
        i_awaddr  = a;
        i_wdata   = d;
        while (!o_awready) begin
            tick();
            n++;
            if (n > 50) begin flag("awready_timeout"); break; end
        end
        tick();
        i_awvalid = 1'b0;
        i_wvalid  = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a, input bit port, input logic [DW-1:0] d, input int lat);
        q_ar.push_back('{port, a});
        q_r.push_back('{d, lat});
        host_read(a);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input bit port, input logic [DW-1:0] d, input int lat);
        q_aw.push_back('{port, a});
        q_w.push_back('{port, d});
        q_b.push_back('{port, lat});
        host_write(a, d);
    endtask

    task automatic drain();
        int n = 0;
        while ((q_r.size() + q_b.size() + q_ar.size() + q_aw.size() + q_w.size()) != 0 && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) flag("drain_timeout");
        tick();
        tick();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ctl"}, {o_arready, o_rvalid, o_awready, o_wready, o_bvalid,
                              o_m_arvalid, o_m_rready, o_m_awvalid, o_m_wvalid, o_m_bready}, '0);
        check({tag, "_rdata"}, o_rdata, '0);
        check({tag, "_addr"}, {o_m_araddr, o_m_awaddr}, '0);
        check({tag, "_wdata"}, o_m_wdata, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        i_sclrn = 1'b0;
        i_arvalid = 1'b0; i_araddr = '0; i_rready = 1'b1;
        i_awvalid = 1'b0; i_awaddr = '0; i_wvalid = 1'b0; i_wdata = '0; i_bready = 1'b1;
        i_m_arready = '0; i_m_rvalid = '0; i_m_rdata = '0;
        i_m_awready = '0; i_m_wready = '0; i_m_bvalid = '0;
        for (int p = 0; p < 2; p++) begin
            ar_stall[p] = 0; r_stall[p] = 0; aw_stall[p] = 0; w_stall[p] = 0; b_stall[p] = 0;
            extra_rvalid[p] = 1'b0;
        end
        rd_val[0] = 32'hDEADBEEF;
        rd_val[1] = 32'h0BADF00D;
        repeat (3) tick();
        check_zero("reset");
        i_sclrn = 1'b1;
        tick();

        // read port 0, no stall
        do_read(11'h004, 1'b0, 32'hDEADBEEF, 3);
        drain();

        // write port 1, wready three cycles after awready, bvalid two cycles late
        w_stall[1] = 3;
        b_stall[1] = 2;
        do_write(11'h408, 1'b1, 32'h12345678, 8);
        drain();
        w_stall[1] = 0;
        b_stall[1] = 0;

        // port 1 behaves as a tie-off
        rd_val[1] = 32'h0;
        do_read(11'h400, 1'b1, 32'h0, 3);
        drain();
        do_write(11'h400, 1'b1, 32'hA5A5A5A5, 3);
        drain();

        // concurrent read port 0 / write port 1 with host rready held low
        rd_val[0] = 32'hCAFEF00D;
        i_rready = 1'b0;
        fork
            do_read(11'h010, 1'b0, 32'hCAFEF00D, 3);
            do_write(11'h40C, 1'b1, 32'h55AA00FF, 3);
            begin
                int n = 0;
                while (!o_rvalid && n < 50) begin tick(); n++; end
                repeat (10) tick();
                i_rready = 1'b1;
            end
        join
        drain();

        // awvalid without wvalid is not accepted
        i_awvalid = 1'b1;
        i_awaddr  = 11'h014;
        i_wvalid  = 1'b0;
        repeat (5) begin
            tick();
            check("awready_without_wvalid", {o_awready, o_wready}, 2'b00);
        end
        do_write(11'h014, 1'b0, 32'h0F0F0F0F, 3);
        drain();

        // unsolicited rvalid on port 1 during a stalled port-0 read
        rd_val[0] = 32'h13579BDF;
        rd_val[1] = 32'hFFFFFFFF;
        r_stall[0] = 4;
        fork
            do_read(11'h020, 1'b0, 32'h13579BDF, 7);
            begin
                repeat (3) tick();
                extra_rvalid[1] = 1'b1;
                tick();
                extra_rvalid[1] = 1'b0;
            end
        join
        drain();
        r_stall[0] = 0;

        // reset while in R_DATA
        r_stall[0] = 5;
        q_ar.push_back('{1'b0, 11'h030});
        host_read(11'h030);
        tick();
        check("rdata_phase_rready", o_m_rready, 2'b01);
        i_sclrn = 1'b0;
        tick();
        check_zero("midreset");
        i_sclrn = 1'b1;
        r_stall[0] = 0;
        rd_val[0] = 32'h2468ACE0;
        tick();
        do_read(11'h030, 1'b0, 32'h2468ACE0, 3);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dla_platform_csr_axi_demux.md
# dla_platform_csr_axi_demux

Routes the single host-facing CSR AXI4-Lite port to one of two CoreDLA CSR ports, selected by one address bit, in the platform shell between the PCIe/host bridge and the per-instance CSR slaves (a live CoreDLA or the CSR tie-off). Allows one outstanding read and one outstanding write, with independent read and write paths. All outputs are registered.

## Interface
Parameters:
- CSR_ADDR_WIDTH, 11, byte address width on both sides; full address is forwarded unchanged.
- CSR_DATA_WIDTH, 32, read/write data width.
- SEL_BIT, 10, address bit selecting the instance (0 → port 0, 1 → port 1); must be < CSR_ADDR_WIDTH.

Ports (m_ vectors are indexed by instance; packed address/data vectors are 2×width, with instance n at slice [n]):
- clk  in  1  sole clock.
- i_sclrn  in  1  reset; **one clock; reset is synchronous and active-low**.
- i_arvalid, i_araddr  in  1, CSR_ADDR_WIDTH  host read address.
- o_arready  out  1  host read-address accept.
- o_rvalid, o_rdata  out  1, CSR_DATA_WIDTH  host read response.
- i_rready  in  1  host read-response accept.
- i_awvalid, i_awaddr, i_wvalid, i_wdata  in  1, CSR_ADDR_WIDTH, 1, CSR_DATA_WIDTH  host write address and data.
- o_awready, o_wready  out  1 each  host write accepts.
- o_bvalid  out  1  host write response.
- i_bready  in  1  host write-response accept.
- o_m_arvalid, o_m_araddr  out  2, 2×CSR_ADDR_WIDTH  per-instance read address.
- i_m_arready  in  2  per-instance read-address accept.
- i_m_rvalid, i_m_rdata  in  2, 2×CSR_DATA_WIDTH  per-instance read response.
- o_m_rready  out  2  per-instance read-response accept.
- o_m_awvalid, o_m_awaddr, o_m_wvalid, o_m_wdata  out  2, 2×CSR_ADDR_WIDTH, 2, 2×CSR_DATA_WIDTH  per-instance write address and data.
- i_m_awready, i_m_wready  in  2 each  per-instance write accepts.
- i_m_bvalid  in  2  per-instance write response.
- o_m_bready  out  2  per-instance write-response accept.

## Operation
- Reset values: every valid and ready output is 0; o_rdata, o_m_araddr, o_m_awaddr, o_m_wdata are 0; both FSMs are in IDLE.
- Read FSM: R_IDLE → R_ADDR → R_DATA → R_RESP → R_IDLE.
  - R_IDLE: o_arready is registered high for exactly one cycle after i_arvalid is seen. On the handshake cycle, capture araddr and sel = araddr[SEL_BIT].
  - R_ADDR: o_m_arvalid[sel] = 1 until i_m_arready[sel] is seen.
  - R_DATA: o_m_rready[sel] = 1. On i_m_rvalid[sel], capture i_m_rdata[sel].
  - R_RESP: o_rvalid = 1 with captured data until i_rready.
- Write FSM: W_IDLE → W_REQ → W_RESP → W_BRESP → W_IDLE.
  - W_IDLE: waits for i_awvalid & i_wvalid both high. Then o_awready and o_wready are registered high together for one cycle. Capture address, data and sel.
  - W_REQ: o_m_awvalid[sel] and o_m_wvalid[sel] are driven independently. Each drops after its own ready; W_RESP is entered once both are accepted (same cycle or different cycles).
  - W_RESP: o_m_bready[sel] = 1 until i_m_bvalid[sel].
  - W_BRESP: o_bvalid = 1 until i_bready.
- Non-selected instance: all its valid and ready outputs stay 0. Its i_m_rvalid and i_m_bvalid are ignored; unsolicited responses are never forwarded.
- The read and write FSMs are fully independent. A concurrent read and write may target the same or different instances.
- Address or data arriving without its partner in W_IDLE: wait, no accept.
- Reset mid-transaction: all FSMs return to IDLE next cycle and in-flight transfers are abandoned. Downstream slaves share i_sclrn.

## Timing
- Read, downstream ready/valid already high when presented: arready handshake at T; o_m_arvalid at T+1; o_m_rready at T+2; o_rvalid at T+3. Earliest next o_arready is at T+5.
- Write, same conditions: accept at T; o_m_awvalid/o_m_wvalid at T+1; o_m_bready at T+2; o_bvalid at T+3.
- Each downstream stall cycle adds exactly one cycle of latency. No combinational path from any input to any output.

## Structure
- Package dla_platform_csr_pkg holds:
  - NUM_CSR_PORTS = 2;
  - the read-state enum (R_IDLE/R_ADDR/R_DATA/R_RESP);
  - the write-state enum (W_IDLE/W_REQ/W_RESP/W_BRESP).
- Flat module, one always_ff per direction; no sub-module is natural. Reset is already synchronous, so no reset handler is instantiated.

## Test plan
- Read 0x004 (SEL_BIT=10); port 0 returns 0xDEADBEEF with zero stall → o_rvalid at T+3 with 0xDEADBEEF; port 1 signals all stay 0.
- Write 0x408 with data 0x12345678 → o_m_awaddr[1] = 0x408, o_m_wdata[1] = 0x12345678; i_m_awready[1] arrives 3 cycles before i_m_wready[1]; o_bvalid rises only after i_m_bvalid[1].
- Port 1 tied off (tie-off stage attached): read 0x400 → o_rdata = 0; write 0x400 completes with o_bvalid.
- Concurrent read of port 0 and write of port 1 issued the same cycle → both complete without interference; i_rready held low 10 cycles → o_rvalid and o_rdata stay stable.
- i_awvalid without i_wvalid for 5 cycles → o_awready stays 0; i_m_rvalid[1] pulsed while a port-0 read is pending → ignored.
- i_sclrn low during R_DATA → next cycle all outputs 0, FSM in R_IDLE; a following read completes normally.
